// File: rtl/bullet_renderer.sv
// Draws a 2x2 bullet sprite through a pixel-at-a-time VGA adapter.
// A moved bullet has its previous sprite erased before it is redrawn.
module bullet_renderer #(
  parameter logic [2:0] FG_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR = 3'b000,
  parameter int         SCREEN_W  = 160,
  parameter int         SCREEN_H  = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bullet_active,
  input  logic [7:0] bullet_x,
  input  logic [6:0] bullet_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

  localparam logic [8:0] SCR_W = 9'(SCREEN_W);
  localparam logic [7:0] SCR_H = 8'(SCREEN_H);

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] snap_x_q, snap_x_d;
  logic [6:0] snap_y_q, snap_y_d;
  logic [7:0] drawn_x_q, drawn_x_d;
  logic [6:0] drawn_y_q, drawn_y_d;
  logic       drawn_valid_q, drawn_valid_d;
  logic       erase_only_q, erase_only_d;
  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] vga_colour_q, vga_colour_d;
  logic       plot_d;

  logic       draw_req;
  logic       erase_req;
  logic       pixel_en;
  logic [2:0] pixel_colour;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [8:0] pix_x;
  logic [7:0] pix_y;
  logic       clipped;

  always_comb begin
    draw_req  = bullet_active &&
                (!drawn_valid_q || (bullet_x != drawn_x_q) || (bullet_y != drawn_y_q));
    erase_req = !bullet_active && drawn_valid_q;
  end

  // Erase works on the last drawn sprite, draw on the snapshot; offsets are
  // widened by one bit so the right/bottom edge never wraps back on screen.
  always_comb begin
    base_x  = (state_q == DRAW) ? snap_x_q : drawn_x_q;
    base_y  = (state_q == DRAW) ? snap_y_q : drawn_y_q;
    pix_x   = {1'b0, base_x} + {8'd0, cnt_q[0]};
    pix_y   = {1'b0, base_y} + {7'd0, cnt_q[1]};
    clipped = (pix_x >= SCR_W) || (pix_y >= SCR_H);
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    snap_x_d      = snap_x_q;
    snap_y_d      = snap_y_q;
    drawn_x_d     = drawn_x_q;
    drawn_y_d     = drawn_y_q;
    drawn_valid_d = drawn_valid_q;
    erase_only_d  = erase_only_q;
    pixel_en      = 1'b0;
    pixel_colour  = BG_COLOUR;

    case (state_q)
      IDLE: begin
        cnt_d = 2'd0;
        if (draw_req) begin
          snap_x_d     = bullet_x;
          snap_y_d     = bullet_y;
          erase_only_d = 1'b0;
          state_d      = drawn_valid_q ? ERASE : DRAW;
        end else if (erase_req) begin
          snap_x_d     = bullet_x;
          snap_y_d     = bullet_y;
          erase_only_d = 1'b1;
          state_d      = ERASE;
        end
      end
      ERASE: begin
        pixel_en     = 1'b1;
        pixel_colour = BG_COLOUR;
        cnt_d        = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          if (erase_only_q) begin
            drawn_valid_d = 1'b0;
            state_d       = DONE;
          end else begin
            state_d = DRAW;
          end
        end
      end
      DRAW: begin
        pixel_en     = 1'b1;
        pixel_colour = FG_COLOUR;
        cnt_d        = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          drawn_x_d     = snap_x_q;
          drawn_y_d     = snap_y_q;
          drawn_valid_d = 1'b1;
          state_d       = DONE;
        end
      end
      DONE: begin
        cnt_d   = 2'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel bus holds its last written value whenever nothing is plotted.
  always_comb begin
    plot_d       = pixel_en && !clipped;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    if (plot_d) begin
      vga_x_d      = pix_x[7:0];
      vga_y_d      = pix_y[6:0];
      vga_colour_d = pixel_colour;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 2'd0;
      snap_x_q      <= 8'd0;
      snap_y_q      <= 7'd0;
      drawn_x_q     <= 8'd0;
      drawn_y_q     <= 7'd0;
      drawn_valid_q <= 1'b0;
      erase_only_q  <= 1'b0;
      vga_x_q       <= 8'd0;
      vga_y_q       <= 7'd0;
      vga_colour_q  <= 3'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      snap_x_q      <= snap_x_d;
      snap_y_q      <= snap_y_d;
      drawn_x_q     <= drawn_x_d;
      drawn_y_q     <= drawn_y_d;
      drawn_valid_q <= drawn_valid_d;
      erase_only_q  <= erase_only_d;
      vga_x_q       <= vga_x_d;
      vga_y_q       <= vga_y_d;
      vga_colour_q  <= vga_colour_d;
    end
  end

  assign vga_x      = vga_x_d;
  assign vga_y      = vga_y_d;
  assign vga_colour = vga_colour_d;
  assign vga_plot   = plot_d;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_bullet_renderer.sv
// Scoreboard bench for bullet_renderer: expected pixel writes are queued when
// a request is driven and compared as the renderer plots them.
module tb_bullet_renderer;

   logic       clock;
   logic       reset;
   logic       bulletActive;
   logic [7:0] bulletX;
   logic [6:0] bulletY;
   logic [7:0] vgaX;
   logic [6:0] vgaY;
   logic [2:0] vgaColour;
   logic       vgaPlot;
   logic       busy;
   logic       done;

   int errors = 0;
   int checks = 0;
   int plotCount = 0;
   int doneFirst, doneLast, doneCount, busyCount;
   logic [18:0] expectedPlots[$];

   bullet_renderer dut (
      .clk(clock),
      .reset(reset),
      .bullet_active(bulletActive),
      .bullet_x(bulletX),
      .bullet_y(bulletY),
      .vga_x(vgaX),
      .vga_y(vgaY),
      .vga_colour(vgaColour),
      .vga_plot(vgaPlot),
      .busy(busy),
      .done(done)
   );

   // Free-running clock, 10 time units per cycle
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single comparison point; every check is counted here
   task automatic checkOutput(input string tag, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Queue the visible pixels of a 2x2 sprite in plot order, skipping off-screen ones
   task automatic pushSprite(input int x, input int y, input logic [2:0] colour);
      for (int k = 0; k < 4; k++) begin
         int px;
         int py;
         logic [7:0] px8;
         logic [6:0] py7;
         px = x + (k % 2);
         py = y + (k / 2);
         px8 = px[7:0];
         py7 = py[6:0];
         if (px < 160 && py < 120)
            expectedPlots.push_back({1'b1, px8, py7, colour});
      end
   endtask

   // Every plot seen on the bus must match the head of the scoreboard
   always @(negedge clock) begin
      if (vgaPlot === 1'b1) begin
         logic [18:0] expected;
         plotCount++;
         expected = (expectedPlots.size() > 0) ? expectedPlots.pop_front() : 19'd0;
         checkOutput("plot_pixel", int'({1'b1, vgaX, vgaY, vgaColour}), int'(expected));
      end
   end

   // Drive the bullet, then watch a fixed number of cycles recording done/busy,
   // optionally moving the bullet at cycle chgAt
   task automatic applyStimulus(input logic act, input int x, input int y, input int n,
                                input int chgAt, input int chgX, input int chgY);
      bulletActive = act;
      bulletX = x[7:0];
      bulletY = y[6:0];
      doneFirst = 0;
      doneLast = 0;
      doneCount = 0;
      busyCount = 0;
      for (int k = 1; k <= n; k++) begin
         @(negedge clock);
         if (done === 1'b1) begin
            doneCount++;
            if (doneFirst == 0) doneFirst = k;
            doneLast = k;
         end
         if (busy === 1'b1) busyCount++;
         if (k == chgAt) begin
            bulletX = chgX[7:0];
            bulletY = chgY[6:0];
         end
      end
   endtask

   // Overall time guard
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1, "[TB] timeout");
   end

   // Main sequence
   initial begin
      int plotsBefore;
      reset = 1'b1;
      bulletActive = 1'b0;
      bulletX = 8'd0;
      bulletY = 7'd0;
      @(negedge clock);
      @(negedge clock);
      checkOutput("reset_vga_x", int'(vgaX), 0);
      checkOutput("reset_vga_y", int'(vgaY), 0);
      checkOutput("reset_colour", int'(vgaColour), 0);
      checkOutput("reset_plot", int'(vgaPlot), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_done", int'(done), 0);
      reset = 1'b0;

      $display("[TB] first draw at (10,20)");
      pushSprite(10, 20, 3'b111);
      applyStimulus(1'b1, 10, 20, 8, 0, 0, 0);
      checkOutput("draw_done_cycle", doneFirst, 5);
      checkOutput("draw_done_count", doneCount, 1);
      checkOutput("draw_busy_cycles", busyCount, 5);
      checkOutput("draw_queue", expectedPlots.size(), 0);

      $display("[TB] move to (11,20)");
      pushSprite(10, 20, 3'b000);
      pushSprite(11, 20, 3'b111);
      applyStimulus(1'b1, 11, 20, 12, 0, 0, 0);
      checkOutput("move_done_cycle", doneFirst, 9);
      checkOutput("move_done_count", doneCount, 1);
      checkOutput("move_busy_cycles", busyCount, 9);
      checkOutput("move_queue", expectedPlots.size(), 0);

      $display("[TB] bullet deactivated");
      pushSprite(11, 20, 3'b000);
      applyStimulus(1'b0, 11, 20, 8, 0, 0, 0);
      checkOutput("erase_done_cycle", doneFirst, 5);
      checkOutput("erase_busy_cycles", busyCount, 5);
      checkOutput("erase_queue", expectedPlots.size(), 0);
      applyStimulus(1'b0, 11, 20, 10, 0, 0, 0);
      checkOutput("inactive_done_count", doneCount, 0);
      checkOutput("inactive_busy_cycles", busyCount, 0);

      $display("[TB] corner draw at (159,119)");
      pushSprite(159, 119, 3'b111);
      applyStimulus(1'b1, 159, 119, 8, 0, 0, 0);
      checkOutput("corner_done_cycle", doneFirst, 5);
      checkOutput("corner_busy_cycles", busyCount, 5);
      checkOutput("corner_queue", expectedPlots.size(), 0);
      checkOutput("corner_hold_x", int'(vgaX), 159);
      checkOutput("corner_hold_y", int'(vgaY), 119);

      $display("[TB] hold position for 50 cycles");
      plotsBefore = plotCount;
      applyStimulus(1'b1, 159, 119, 50, 0, 0, 0);
      checkOutput("hold_done_count", doneCount, 0);
      checkOutput("hold_busy_cycles", busyCount, 0);
      checkOutput("hold_plots", plotCount - plotsBefore, 0);

      $display("[TB] move during DRAW");
      pushSprite(159, 119, 3'b000);
      pushSprite(30, 40, 3'b111);
      pushSprite(30, 40, 3'b000);
      pushSprite(31, 41, 3'b111);
      applyStimulus(1'b1, 30, 40, 22, 6, 31, 41);
      checkOutput("midmove_done_count", doneCount, 2);
      checkOutput("midmove_first_done", doneFirst, 9);
      checkOutput("midmove_last_done", doneLast, 19);
      checkOutput("midmove_queue", expectedPlots.size(), 0);

      $display("[TB] reset during DRAW");
      reset = 1'b1;
      bulletActive = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      expectedPlots.push_back({1'b1, 8'd50, 7'd60, 3'b111});
      expectedPlots.push_back({1'b1, 8'd51, 7'd60, 3'b111});
      bulletActive = 1'b1;
      bulletX = 8'd50;
      bulletY = 7'd60;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("abort_plot", int'(vgaPlot), 0);
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_vga_x", int'(vgaX), 0);
      checkOutput("abort_queue", expectedPlots.size(), 0);
      pushSprite(50, 60, 3'b111);
      reset = 1'b0;
      applyStimulus(1'b1, 50, 60, 8, 0, 0, 0);
      checkOutput("redraw_done_cycle", doneFirst, 5);
      checkOutput("redraw_busy_cycles", busyCount, 5);
      checkOutput("redraw_queue", expectedPlots.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bullet_renderer.md
BULLET_RENDERER -- requirements
Module: bullet_renderer

Interface
REQ-001 Parameter FG_COLOUR, default 3'b111, bullet pixel colour.
REQ-002 Parameter BG_COLOUR, default 3'b000, erase colour.
REQ-003 Parameter SCREEN_W, default 160, visible columns 0..SCREEN_W-1.
REQ-004 Parameter SCREEN_H, default 120, visible rows 0..SCREEN_H-1.
REQ-005 Ports SHALL be exactly as follows; reset is synchronous, active-high; clock is clk.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 bullet_active  in  1  level; bullet in flight and to be shown.
REQ-009 bullet_x  in  8  bullet top-left column.
REQ-010 bullet_y  in  7  bullet top-left row.
REQ-011 vga_x  out  8  pixel column to VGA adapter.
REQ-012 vga_y  out  7  pixel row to VGA adapter.
REQ-013 vga_colour  out  3  pixel colour.
REQ-014 vga_plot  out  1  write strobe; pixel written when high.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 done  out  1  one-cycle pulse at end of each operation.

Function
REQ-017 Sprite SHALL be 2x2 pixels, in order: (x,y), (x+1,y), (x,y+1), (x+1,y+1); x+1 and y+1 computed at 9/8 bits, no wrap.
REQ-018 States SHALL be IDLE, ERASE, DRAW, DONE; 2-bit pixel counter indexes sprite pixels 0..3.
REQ-019 Internal drawn_x/drawn_y/drawn_valid SHALL record last sprite fully drawn.
REQ-020 In IDLE, draw request = bullet_active and (not drawn_valid or (bullet_x,bullet_y) differ from (drawn_x,drawn_y)).
REQ-021 In IDLE, erase-only request = not bullet_active and drawn_valid.
REQ-022 On either request in IDLE cycle N, bullet_x/bullet_y SHALL be snapshotted; inputs then ignored until return to IDLE.
REQ-023 Draw request with drawn_valid=1: IDLE -> ERASE; with drawn_valid=0: IDLE -> DRAW.
REQ-024 Erase-only request: IDLE -> ERASE; after ERASE -> DONE, drawn_valid cleared.
REQ-025 ERASE SHALL occupy exactly 4 cycles, pixel k on cycle k, at drawn_x/drawn_y, colour BG_COLOUR.
REQ-026 DRAW SHALL occupy exactly 4 cycles, pixel k on cycle k, at snapshot position, colour FG_COLOUR.
REQ-027 After DRAW: drawn_x/drawn_y <= snapshot, drawn_valid <= 1, state -> DONE.
REQ-028 DONE SHALL last one cycle with done=1, then -> IDLE; done=0 in all other states.
REQ-029 Timing: request seen cycle N; ERASE N+1..N+4; DRAW N+5..N+8 (N+1..N+4 if no erase); DONE next cycle; IDLE following.
REQ-030 Pixel with column >= SCREEN_W or row >= SCREEN_H SHALL be clipped: vga_plot=0 that cycle, cycle still consumed.
REQ-031 vga_plot SHALL be 0 in IDLE and DONE; vga_x/vga_y/vga_colour hold last value when vga_plot=0.
REQ-032 Active and position unchanged with drawn_valid=1: no operation, no plot, no done.
REQ-033 Position changes during an operation: picked up at next IDLE cycle by REQ-020 comparison; no intermediate positions required.

Reset
REQ-034 Reset SHALL force state IDLE, counter 0, drawn_valid 0, drawn_x/drawn_y 0, vga_x/vga_y/vga_colour 0, vga_plot 0, busy 0, done 0.
REQ-035 Reset mid-operation SHALL abort on the next edge with no further plots; partially drawn pixels remain on screen.
REQ-036 Reset SHALL take priority over all requests in the same cycle.

Verification
REQ-037 Reset, then active=1, x=10, y=20 -> DRAW plots (10,20),(11,20),(10,21),(11,21) colour 111, done pulse, busy 5 cycles.
REQ-038 Drawn at (10,20), move to (11,20) -> erase 4 pixels at (10,20) colour 000, then draw at (11,20); done 9 cycles after request cycle.
REQ-039 Drawn at (11,20), active falls -> 4 erase plots at (11,20), done, then no activity with active=0.
REQ-040 Active at x=159, y=119 -> only (159,119) plotted; other 3 cycles vga_plot=0; busy still 5 cycles.
REQ-041 Position held constant 50 cycles after draw -> no vga_plot, no done; position changed during DRAW -> next operation starts first IDLE cycle.
REQ-042 Reset asserted on 2nd DRAW cycle -> vga_plot=0, busy=0 from next edge; re-request draws without erase.
